// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte stream between N_CH requesters.
// One registered output stage feeds uart_tx; grants end on last byte, idle timeout or max length.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_CH    = 4,
  parameter int MAX_LEN = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           s_vld,
  input  logic [8*N_CH-1:0]         s_data,
  input  logic [N_CH-1:0]           s_last,
  output logic [N_CH-1:0]           s_rdy,
  output logic                      o_vld,
  output logic [7:0]                o_data,
  input  logic                      i_rdy,
  output logic [N_CH-1:0]           o_grant,
  output logic                      o_timeout,
  output logic                      o_overlen,
  output logic [$clog2(N_CH)-1:0]   o_evt_ch
);

  localparam int CW = $clog2(N_CH);
  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] LEN_LAST  = BW'(MAX_LEN - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [CW-1:0]   gidx_q, gidx_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            o_vld_q, o_vld_d;
  logic [7:0]      o_data_q, o_data_d;
  logic            timeout_q, timeout_d;
  logic            overlen_q, overlen_d;
  logic [CW-1:0]   evt_ch_q, evt_ch_d;

  logic            room;
  logic            g_vld;
  logic            g_last;
  logic [7:0]      g_data;
  logic            accept;
  logic            found;
  logic [CW-1:0]   win;
  logic [CW-1:0]   idx;

  // The output register can take a new byte whenever it is empty or draining this cycle.
  assign room   = !o_vld_q || i_rdy;
  assign g_vld  = |(s_vld & grant_q);
  assign g_last = |(s_last & grant_q);
  assign g_data = s_data[8*gidx_q +: 8];
  assign accept = (state_q == S_XFER) && g_vld && room;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rdy
    assign s_rdy[gi] = (state_q == S_XFER) && grant_q[gi] && room;
  end

  // Round-robin search starts one past the last released channel.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CW'((int'(rr_ptr_q) + i) % N_CH);
      if (!found && s_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    o_vld_d    = o_vld_q;
    o_data_d   = o_data_q;
    timeout_d  = 1'b0;
    overlen_d  = 1'b0;
    evt_ch_d   = evt_ch_q;

    if (accept) begin
      o_vld_d  = 1'b1;
      o_data_d = g_data;
    end else if (i_rdy) begin
      o_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_XFER;
          grant_d    = {{(N_CH-1){1'b0}}, 1'b1} << win;
          gidx_d     = win;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      default: begin
        if (accept) byte_cnt_d = byte_cnt_q + 1'b1;
        idle_cnt_d = g_vld ? '0 : idle_cnt_q + 1'b1;
        // End of packet takes precedence over the length cut on the same byte.
        if (accept && g_last) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          rr_ptr_d = gidx_q;
        end else if (accept && byte_cnt_q == LEN_LAST) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          rr_ptr_d  = gidx_q;
          overlen_d = 1'b1;
          evt_ch_d  = gidx_q;
        end else if (TIMEOUT != 0 && !g_vld && idle_cnt_q == IDLE_LAST) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          rr_ptr_d  = gidx_q;
          timeout_d = 1'b1;
          evt_ch_d  = gidx_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= CW'(N_CH - 1);
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      o_vld_q    <= 1'b0;
      o_data_q   <= '0;
      timeout_q  <= 1'b0;
      overlen_q  <= 1'b0;
      evt_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      o_vld_q    <= o_vld_d;
      o_data_q   <= o_data_d;
      timeout_q  <= timeout_d;
      overlen_q  <= overlen_d;
      evt_ch_q   <= evt_ch_d;
    end
  end

  assign o_vld     = o_vld_q;
  assign o_data    = o_data_q;
  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;
  assign o_overlen = overlen_q;
  assign o_evt_ch  = evt_ch_q;

endmodule
